// File: rtl/sram_responder.sv
// Clocked responder for a 16-bit asynchronous SRAM bus: byte-lane writes, reads with programmable latency, sticky error flags.
// Define SRAM_RESP_CLEAR_EN to zero the whole array with a post-reset sweep (busy high while it runs).
module sram_responder #(
  parameter int addrBit     = 20,
  parameter int dataBit     = 16,
  parameter int depthBit    = 10,
  parameter int readLatency = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [addrBit-1:0]  SRAM_ADDRESS,
  inout  wire  [dataBit-1:0]  SRAM_DATA_IO,
  input  logic                SRAM_UB_N,
  input  logic                SRAM_LB_N,
  input  logic                SRAM_WE_N,
  input  logic                SRAM_CE_N,
  input  logic                SRAM_OE_N,
  output logic                busy,
  output logic                rangeErr,
  output logic                conflictErr,
  output logic [15:0]         writeCount,
  output logic [15:0]         readCount
);

  localparam int DEPTH = 1 << depthBit;
  localparam logic [2:0] LAT_LOAD = 3'(readLatency - 1);

  typedef enum logic [1:0] {IDLE, RLAT, RDRIVE} state_t;

  state_t              state_q, state_d;
  logic [depthBit-1:0] raddr_q, raddr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                range_err_q, range_err_d;
  logic                conflict_err_q, conflict_err_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d;
  logic [15:0]         rd_cnt_q, rd_cnt_d;

  logic [dataBit-1:0]  mem_q [DEPTH];
  logic                mem_we;
  logic [1:0]          mem_be;
  logic [depthBit-1:0] mem_waddr;
  logic [dataBit-1:0]  mem_wdata;

  logic                is_wr, is_rd, in_range, same_addr, sweep_busy, drive;
  logic [depthBit-1:0] acc_addr;
  logic [dataBit-1:0]  rdata;

  assign is_wr     = !SRAM_CE_N && !SRAM_WE_N;
  assign is_rd     = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign in_range  = (SRAM_ADDRESS[addrBit-1:depthBit] == '0);
  assign acc_addr  = SRAM_ADDRESS[depthBit-1:0];
  assign same_addr = (acc_addr == raddr_q);

`ifdef SRAM_RESP_CLEAR_EN
  logic                sweep_q, sweep_d;
  logic [depthBit-1:0] clr_q, clr_d;

  always_comb begin
    sweep_d = sweep_q;
    clr_d   = clr_q;
    if (sweep_q) begin
      clr_d = clr_q + depthBit'(1);
      if (clr_q == '1) sweep_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_q <= 1'b1;
      clr_q   <= '0;
    end else begin
      sweep_q <= sweep_d;
      clr_q   <= clr_d;
    end
  end

  assign sweep_busy = sweep_q;
`else
  assign sweep_busy = 1'b0;
`endif

  assign busy = sweep_busy;

  always_comb begin
    state_d        = state_q;
    raddr_d        = raddr_q;
    cnt_d          = cnt_q;
    range_err_d    = range_err_q;
    conflict_err_d = conflict_err_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    mem_we         = 1'b0;
    mem_be         = {!SRAM_UB_N, !SRAM_LB_N};
    mem_waddr      = acc_addr;
    mem_wdata      = SRAM_DATA_IO;

    if (sweep_busy) begin
      if (is_wr || is_rd) conflict_err_d = 1'b1;
`ifdef SRAM_RESP_CLEAR_EN
      mem_we    = 1'b1;
      mem_be    = 2'b11;
      mem_waddr = clr_q;
      mem_wdata = '0;
`endif
    end else if (is_wr) begin
      state_d = IDLE;
      if (!SRAM_OE_N) conflict_err_d = 1'b1;
      if (in_range) begin
        mem_we   = 1'b1;
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        range_err_d = 1'b1;
      end
    end else if (is_rd && !in_range) begin
      range_err_d = 1'b1;
      state_d     = IDLE;
    end else begin
      // Any read that is not a continuation of the latched one starts a fresh latency window.
      case (state_q)
        IDLE: begin
          if (is_rd) begin
            state_d  = RLAT;
            raddr_d  = acc_addr;
            cnt_d    = LAT_LOAD;
            rd_cnt_d = rd_cnt_q + 16'd1;
          end
        end
        RLAT: begin
          if (is_rd && same_addr) begin
            if (cnt_q == 3'd0) state_d = RDRIVE;
            else               cnt_d   = cnt_q - 3'd1;
          end else if (is_rd) begin
            raddr_d  = acc_addr;
            cnt_d    = LAT_LOAD;
            rd_cnt_d = rd_cnt_q + 16'd1;
          end else begin
            state_d = IDLE;
          end
        end
        RDRIVE: begin
          if (is_rd && !same_addr) begin
            state_d  = RLAT;
            raddr_d  = acc_addr;
            cnt_d    = LAT_LOAD;
            rd_cnt_d = rd_cnt_q + 16'd1;
          end else if (!is_rd) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      raddr_q        <= '0;
      cnt_q          <= '0;
      range_err_q    <= 1'b0;
      conflict_err_q <= 1'b0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      raddr_q        <= raddr_d;
      cnt_q          <= cnt_d;
      range_err_q    <= range_err_d;
      conflict_err_q <= conflict_err_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      if (mem_be[1]) mem_q[mem_waddr][dataBit-1:8] <= mem_wdata[dataBit-1:8];
      if (mem_be[0]) mem_q[mem_waddr][7:0]         <= mem_wdata[7:0];
    end
  end

  // A master asserting WE_N owns the bus, so the read driver backs off immediately.
  assign drive = (state_q == RDRIVE) && SRAM_WE_N;
  assign rdata = mem_q[raddr_q];

  assign SRAM_DATA_IO[dataBit-1:8] = (drive && !SRAM_UB_N) ? rdata[dataBit-1:8] : 'z;
  assign SRAM_DATA_IO[7:0]         = (drive && !SRAM_LB_N) ? rdata[7:0]         : 'z;

  assign rangeErr    = range_err_q;
  assign conflictErr = conflict_err_q;
  assign writeCount  = wr_cnt_q;
  assign readCount   = rd_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed bus scenarios plus random traffic against a behavioural model.
// An undriven bus reads back as all ones through a pullup.
module tb_sram_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        busy, range_err, conflict_err;
  logic [15:0] write_count, read_count;
  wire  [15:0] sram_data;
  logic        tb_oe;
  logic [15:0] tb_wdata;

  assign sram_data = tb_oe ? tb_wdata : 16'hzzzz;
  pullup (sram_data);

  always #5 clk = ~clk;

  sram_responder #(
    .addrBit(20), .dataBit(16), .depthBit(10), .readLatency(LAT)
  ) dut (
    .clk(clk), .rst(rst), .SRAM_ADDRESS(addr), .SRAM_DATA_IO(sram_data),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .busy(busy), .rangeErr(range_err), .conflictErr(conflict_err),
    .writeCount(write_count), .readCount(read_count)
  );

  int total = 0;
  int bad   = 0;

  // Model: a read "run" is a streak of consecutive read cycles at one in-range address;
  // data appears once the streak is LAT edges old.
  logic [15:0] mdl_mem [1024];
  logic [15:0] mdl_wc, mdl_rc;
  logic        mdl_rerr, mdl_cerr;
  logic        run_valid;
  logic [9:0]  run_addr;
  int          run_age;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function logic [15:0] expBus();
    logic drv;
    drv = run_valid && (run_age >= LAT);
    expBus[15:8] = (drv && !ub_n) ? mdl_mem[run_addr][15:8] : 8'hFF;
    expBus[7:0]  = (drv && !lb_n) ? mdl_mem[run_addr][7:0]  : 8'hFF;
  endfunction

  task modelReset();
    mdl_wc = '0; mdl_rc = '0; mdl_rerr = 1'b0; mdl_cerr = 1'b0; run_valid = 1'b0; run_age = 0;
  endtask

  task modelEdge();
    logic in_r;
    in_r = (addr[19:10] == 10'd0);
    if (rst) begin
      modelReset();
    end else if (!ce_n && !we_n) begin
      run_valid = 1'b0;
      if (!oe_n) mdl_cerr = 1'b1;
      if (in_r) begin
        if (!ub_n) mdl_mem[addr[9:0]][15:8] = tb_wdata[15:8];
        if (!lb_n) mdl_mem[addr[9:0]][7:0]  = tb_wdata[7:0];
        mdl_wc = mdl_wc + 16'd1;
      end else mdl_rerr = 1'b1;
    end else if (!ce_n && !oe_n) begin
      if (!in_r) begin
        mdl_rerr = 1'b1; run_valid = 1'b0;
      end else if (run_valid && addr[9:0] == run_addr) begin
        if (run_age < 100) run_age++;
      end else begin
        run_valid = 1'b1; run_addr = addr[9:0]; run_age = 0; mdl_rc = mdl_rc + 16'd1;
      end
    end else run_valid = 1'b0;
  endtask

  task applyStimulus(input logic r, input logic c, input logic w, input logic o,
                     input logic u, input logic l, input logic [19:0] a, input logic [15:0] d);
    rst = r; ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a;
    tb_wdata = d; tb_oe = !w;
    @(negedge clk);
    checkOutput("busy", {31'b0, busy}, 32'd0);
    checkOutput("range_err", {31'b0, range_err}, {31'b0, mdl_rerr});
    checkOutput("conflict_err", {31'b0, conflict_err}, {31'b0, mdl_cerr});
    checkOutput("write_count", {16'b0, write_count}, {16'b0, mdl_wc});
    checkOutput("read_count", {16'b0, read_count}, {16'b0, mdl_rc});
    if (!tb_oe) checkOutput("bus", {16'b0, sram_data}, {16'b0, expBus()});
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task doWrite(input logic [19:0] a, input logic [15:0] d, input logic u, input logic l, input logic o);
    applyStimulus(1'b0, 1'b0, 1'b0, o, u, l, a, d);
  endtask

  task doRead(input logic [19:0] a, input logic u, input logic l);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, u, l, a, 16'h0);
  endtask

  task doIdle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [19:0] ra;
  logic [9:0]  last_ra;
  logic        ru, rl, ro;
  int          op, n;

  initial begin
    rst = 1'b1; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    addr = '0; tb_oe = 1'b0; tb_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    modelReset();
`ifdef SRAM_RESP_CLEAR_EN
    checkOutput("busy_in_reset", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("busy_len", n, 32'd1024);
    for (int k = 0; k < 1024; k++) mdl_mem[k] = 16'h0000;
    doRead(20'h0, 1'b0, 1'b0);
    doRead(20'h0, 1'b0, 1'b0);
    doRead(20'h0, 1'b0, 1'b0);
    checkOutput("clear_word0", {16'b0, sram_data}, 32'h0000);
    doIdle();
`endif
    doIdle();

    for (int k = 0; k < 16; k++) doWrite(20'(k), 16'($urandom), 1'b0, 1'b0, 1'b1);
    doIdle();

    doWrite(20'd5, 16'hA55A, 1'b0, 1'b0, 1'b1);
    repeat (3) doRead(20'd5, 1'b0, 1'b0);
    checkOutput("a55a_data", {16'b0, sram_data}, 32'hA55A);
    doIdle();

    doWrite(20'd6, 16'h1234, 1'b0, 1'b0, 1'b1);
    doWrite(20'd6, 16'hAB00, 1'b1, 1'b0, 1'b1);
    repeat (3) doRead(20'd6, 1'b0, 1'b0);
    checkOutput("lane_merge", {16'b0, sram_data}, 32'h1200);
    doRead(20'd6, 1'b0, 1'b1);
    checkOutput("upper_only", {16'b0, sram_data}, 32'h12FF);
    doIdle();

    doRead(20'd7, 1'b0, 1'b0);
    doRead(20'd8, 1'b0, 1'b0);
    doRead(20'd8, 1'b0, 1'b0);
    checkOutput("restart_no_drive", {16'b0, sram_data}, 32'hFFFF);
    doRead(20'd8, 1'b0, 1'b0);
    checkOutput("restart_data", {16'b0, sram_data}, {16'b0, mdl_mem[8]});
    doIdle();

    doWrite(20'd3, 16'h00FF, 1'b0, 1'b0, 1'b0);
    checkOutput("conflict_set", {31'b0, conflict_err}, 32'd1);
    doIdle();
    repeat (3) doRead(20'd3, 1'b0, 1'b0);
    checkOutput("conflict_data", {16'b0, sram_data}, 32'h00FF);
    doIdle();

    doWrite(20'h00400, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    checkOutput("range_set", {31'b0, range_err}, 32'd1);
    repeat (3) doRead(20'd0, 1'b0, 1'b0);
    checkOutput("range_mem0", {16'b0, sram_data}, {16'b0, mdl_mem[0]});
    doIdle();

`ifndef SRAM_RESP_CLEAR_EN
    repeat (3) doRead(20'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'd5, 16'h0);
    checkOutput("reset_release", {16'b0, sram_data}, 32'hFFFF);
    checkOutput("reset_rcount", {16'b0, read_count}, 32'd0);
    doIdle();
`endif

    last_ra = 10'd2;
    for (int i = 0; i < 700; i++) begin
      op = $urandom_range(0, 99);
      ru = ($urandom_range(0, 4) == 0);
      rl = !ru && ($urandom_range(0, 4) == 0);
      ro = ($urandom_range(0, 19) != 0);
      ra = 20'($urandom_range(0, 15));
      if (op < 1) begin
`ifndef SRAM_RESP_CLEAR_EN
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
`else
        doIdle();
`endif
      end else if (op < 4) begin
        ra = {10'($urandom_range(1, 1023)), 10'($urandom_range(0, 15))};
        if ($urandom_range(0, 1) == 0) doWrite(ra, 16'($urandom), ru, rl, ro);
        else                           doRead(ra, ru, rl);
      end else if (op < 30) begin
        doWrite(ra, 16'($urandom), ru, rl, ro);
      end else if (op < 85) begin
        if ($urandom_range(0, 3) != 0) ra = {10'd0, last_ra};
        last_ra = ra[9:0];
        doRead(ra, ru, rl);
      end else if (op < 93) begin
        doIdle();
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, ru, rl, ra, 16'h0);
      end
    end
    doIdle();

`ifdef SRAM_RESP_CLEAR_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 20'd9; tb_wdata = 16'h5555; tb_oe = 1'b1;
    @(posedge clk); #1;
    checkOutput("sweep_conflict", {31'b0, conflict_err}, 32'd1);
    checkOutput("sweep_wcount", {16'b0, write_count}, 32'd0);
    ce_n = 1'b1; we_n = 1'b1; tb_oe = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
